kb_multi_key_decoder: RTL

Parametrised PS/2 scan-code decoder that tracks the make/break state of NUM_KEYS keys from one shared byte stream. It sits directly behind ps2_rx and replaces the per-key single-code controllers with one block. Over the per-key controllers it adds:
- extended (E0-prefixed) code support;
- per-key press, release and typematic-repeat pulses;
- a prefix timeout that recovers from truncated sequences.

---
 rtl/kb_multi_key_decoder_if.sv | 39 +++
 rtl/kb_multi_key_decoder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/kb_multi_key_decoder_if.sv
// Byte stream from ps2_rx into the decoder, plus per-key status and parser debug view back out.
// scan_done_tick is a one-cycle strobe qualifying scan_code; there is no back-pressure, so every strobed byte is consumed in that cycle.
interface kb_multi_key_decoder_if #(
    parameter int NUM_KEYS = 6
);
    logic                scan_done_tick;
    logic [7:0]          scan_code;
    logic [NUM_KEYS-1:0] key_held;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_repeat;
    logic [NUM_KEYS-1:0] key_release;
    logic                any_held;
    logic                prefix_timeout;
    logic [1:0]          dbg_state;

    modport master (
        output scan_done_tick,
        output scan_code,
        input  key_held,
        input  key_press,
        input  key_repeat,
        input  key_release,
        input  any_held,
        input  prefix_timeout,
        input  dbg_state
    );

    modport slave (
        input  scan_done_tick,
        input  scan_code,
        output key_held,
        output key_press,
        output key_repeat,
        output key_release,
        output any_held,
        output prefix_timeout,
        output dbg_state
    );
endinterface

// File: rtl/kb_multi_key_decoder.sv
// PS/2 scan-code decoder: tracks make/break state of NUM_KEYS keys (with E0-extended codes)
// from one byte stream, emitting press/repeat/release pulses and abandoning stale prefixes.
module kb_multi_key_decoder #(
    parameter int                    NUM_KEYS       = 6,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h05A, 9'h02D, 9'h01B, 9'h01D, 9'h023, 9'h01C},
    parameter int                    PREFIX_TIMEOUT = 2_000_000
) (
    input logic                   clk,
    input logic                   reset,
    kb_multi_key_decoder_if.slave bus
);

    localparam int CW = (PREFIX_TIMEOUT > 0) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((PREFIX_TIMEOUT > 0) ? PREFIX_TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (PREFIX_TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] repeat_q, repeat_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic                any_held_q, any_held_d;

    logic                is_data;
    logic                ext_flag;
    logic                brk_flag;
    logic [8:0]          data_key;

    assign ext_flag = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign brk_flag = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    assign data_key = {ext_flag, bus.scan_code};

    // Parser: a tick always beats a coincident timeout expiry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        timeout_d = 1'b0;
        is_data   = 1'b0;
        if (bus.scan_done_tick) begin
            if (bus.scan_code == 8'hE0) begin
                state_d = ST_EXT;
            end else if (bus.scan_code == 8'hF0) begin
                case (state_q)
                    ST_IDLE: state_d = ST_BRK;
                    ST_EXT:  state_d = ST_EXT_BRK;
                    default: state_d = state_q;
                endcase
            end else begin
                is_data = 1'b1;
                state_d = ST_IDLE;
            end
        end else if (TIMEOUT_EN && (state_q != ST_IDLE)) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = ST_IDLE;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Every slice is compared in parallel so duplicate codes update together.
    always_comb begin
        held_d    = held_q;
        press_d   = '0;
        repeat_d  = '0;
        release_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (is_data && (KEY_CODES[9*i +: 9] == data_key)) begin
                if (brk_flag) begin
                    release_d[i] = held_q[i];
                    held_d[i]    = 1'b0;
                end else begin
                    press_d[i]  = ~held_q[i];
                    repeat_d[i] = held_q[i];
                    held_d[i]   = 1'b1;
                end
            end
        end
    end

    assign any_held_d = |held_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            held_q     <= '0;
            press_q    <= '0;
            repeat_q   <= '0;
            release_q  <= '0;
            any_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            held_q     <= held_d;
            press_q    <= press_d;
            repeat_q   <= repeat_d;
            release_q  <= release_d;
            any_held_q <= any_held_d;
        end
    end

    assign bus.key_held       = held_q;
    assign bus.key_press      = press_q;
    assign bus.key_repeat     = repeat_q;
    assign bus.key_release    = release_q;
    assign bus.any_held       = any_held_q;
    assign bus.prefix_timeout = timeout_q;
    assign bus.dbg_state      = state_q;

endmodule
